// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE weight-load controller.
// Holds the controller state encoding and the legal one-hot mode codes.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam logic [2:0] MOD_TYPE_A = 3'b001;
  localparam logic [2:0] MOD_TYPE_B = 3'b010;
  localparam logic [2:0] MOD_TYPE_C = 3'b100;

endpackage

// File: rtl/pe_wcount.sv
// Two-level weight counter: tap index within a channel, then channel index.
// The tap limit is supplied at runtime; last flags the final tap of the final channel.
module pe_wcount #(
  parameter int ADDR_W = 5,
  parameter int CH_W   = 2,
  parameter int NUM_CH = 4,
  parameter int LIM_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [LIM_W-1:0]  limit,
  output logic [ADDR_W-1:0] addr,
  output logic [CH_W-1:0]   ch,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              tap_last;
  logic              ch_last;

  // The address is widened to the limit's width so the compare never truncates.
  assign tap_last = (LIM_W'(addr_q) == (limit - LIM_W'(1)));
  assign ch_last  = (ch_q == CH_W'(NUM_CH - 1));

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_d = addr_q;
    ch_d   = ch_q;
    if (clr) begin
      addr_d = '0;
      ch_d   = '0;
    end else if (inc) begin
      if (tap_last) begin
        addr_d = '0;
        ch_d   = ch_last ? '0 : ch_q + CH_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      ch_q   <= '0;
    end else begin
      addr_q <= addr_d;
      ch_q   <= ch_d;
    end
  end

  assign addr = addr_q;
  assign ch   = ch_q;
  assign last = tap_last && ch_last;

endmodule

// File: rtl/pe_weight_load_ctrl.sv
// PE controller: on a stable one-hot mode, clears the PE, streams ksize^2 weights
// into each channel over valid/ready, then enables processing until reload or mode change.
module pe_weight_load_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int MODE_W     = 3,
  parameter int KERNEL_MAX = 5,
  parameter int NUM_CH     = 4,
  parameter int KS_W       = $clog2(KERNEL_MAX + 1),
  parameter int ADDR_W     = $clog2(KERNEL_MAX * KERNEL_MAX),
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] mode,
  input  logic [KS_W-1:0]   ksize,
  input  logic              reload,
  input  logic              w_valid,
  output logic              w_ready,
  output logic              weight_we,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [CH_W-1:0]   weight_ch,
  output logic              clr_pulse,
  output logic              process_enable,
  output logic              busy,
  output logic              err
);

  localparam int KSQ_W = 2 * KS_W;

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [KS_W-1:0]   ksize_q, ksize_d;
  logic              w_ready_q, w_ready_d;

  logic              mode_chg;
  logic              mode_ok;
  logic              ksize_bad;
  logic              wr_fire;
  logic [KSQ_W-1:0]  ksq;
  logic [ADDR_W-1:0] cnt_addr;
  logic [CH_W-1:0]   cnt_ch;
  logic              cnt_last;

  assign mode_chg  = (mode != mode_q);
  assign mode_ok   = (mode_q != '0) && ((mode_q & (mode_q - MODE_W'(1))) == '0);
  assign ksize_bad = (ksize == '0) || (ksize > KS_W'(KERNEL_MAX));
  assign ksq       = KSQ_W'(ksize_q) * KSQ_W'(ksize_q);
  // A mode change kills the write in the same cycle it aborts the load.
  assign wr_fire   = w_valid & w_ready_q & ~mode_chg;

  pe_wcount #(
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W),
    .NUM_CH (NUM_CH),
    .LIM_W  (KSQ_W)
  ) u_wcount (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == CLEAR),
    .inc   (wr_fire),
    .limit (ksq),
    .addr  (cnt_addr),
    .ch    (cnt_ch),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // mode_chg outranks last-beat and reload in every non-idle state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (mode_ok && !mode_chg) state_d = CLEAR;
      CLEAR: begin
        if (mode_chg)       state_d = IDLE;
        else if (ksize_bad) state_d = ERR;
        else                state_d = LOAD;
      end
      LOAD: begin
        if (mode_chg)                 state_d = IDLE;
        else if (wr_fire && cnt_last) state_d = RUN;
      end
      RUN: begin
        if (mode_chg)    state_d = IDLE;
        else if (reload) state_d = CLEAR;
      end
      ERR:     if (mode_chg) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d    = mode;
    ksize_d   = (state_q == CLEAR) ? ksize : ksize_q;
    w_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      ksize_q   <= '0;
      w_ready_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      ksize_q   <= ksize_d;
      w_ready_q <= w_ready_d;
    end
  end

  // Address and channel are only exposed while loading so aborted loads leave nothing visible.
  always_comb begin
    clr_pulse      = 1'b0;
    process_enable = 1'b0;
    busy           = 1'b0;
    err            = 1'b0;
    weight_addr    = '0;
    weight_ch      = '0;
    case (state_q)
      CLEAR: begin
        clr_pulse = 1'b1;
        busy      = 1'b1;
      end
      LOAD: begin
        busy        = 1'b1;
        weight_addr = cnt_addr;
        weight_ch   = cnt_ch;
      end
      RUN:     process_enable = 1'b1;
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  assign w_ready   = w_ready_q;
  assign weight_we = wr_fire;

endmodule

// File: tb/tb_pe_weight_load_ctrl.sv
// Directed bench for pe_weight_load_ctrl: a single-channel and a four-channel instance
// share stimulus; a vector table plus hand sequences cover load, abort, error and reload.
module tb_pe_weight_load_ctrl;
  import pe_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] mode;
  logic [2:0] ksize;
  logic       reload;
  logic       w_valid;

  logic       rdy1, we1, clr1, pe1, busy1, err1;
  logic [4:0] addr1;
  logic [0:0] ch1;
  logic       rdy4, we4, clr4, pe4, busy4, err4;
  logic [4:0] addr4;
  logic [1:0] ch4;

  int checks   = 0;
  int failures = 0;

  pe_weight_load_ctrl #(.MODE_W(3), .KERNEL_MAX(5), .NUM_CH(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .ksize(ksize), .reload(reload),
    .w_valid(w_valid), .w_ready(rdy1), .weight_we(we1), .weight_addr(addr1),
    .weight_ch(ch1), .clr_pulse(clr1), .process_enable(pe1), .busy(busy1), .err(err1)
  );

  pe_weight_load_ctrl #(.MODE_W(3), .KERNEL_MAX(5), .NUM_CH(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .ksize(ksize), .reload(reload),
    .w_valid(w_valid), .w_ready(rdy4), .weight_we(we4), .weight_addr(addr4),
    .weight_ch(ch4), .clr_pulse(clr4), .process_enable(pe4), .busy(busy4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {we, addr[4:0], ch[1:0], clr, pe, busy, err, rdy}
  function automatic logic [15:0] p4(input logic we, input logic [4:0] a, input logic [1:0] c,
                                     input logic clr, input logic pe, input logic bsy,
                                     input logic er, input logic rd);
    return {3'b000, we, a, c, clr, pe, bsy, er, rd};
  endfunction

  function automatic logic [15:0] wr(input logic [4:0] a, input logic [1:0] c);
    return p4(1'b1, a, c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic logic [15:0] act1();
    return p4(we1, addr1, {1'b0, ch1}, clr1, pe1, busy1, err1, rdy1);
  endfunction

  function automatic logic [15:0] act4();
    return p4(we4, addr4, ch4, clr4, pe4, busy4, err4, rdy4);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    mode    = 3'b000;
    ksize   = 3'd0;
    reload  = 1'b0;
    w_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [2:0]  ks;
    logic        wv;
    logic        rl;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[28];

  task automatic put(input int i, input logic [2:0] m, input logic [2:0] k,
                     input logic v, input logic r, input logic [15:0] e);
    tbl[i] = '{mode: m, ks: k, wv: v, rl: r, exp: e};
  endtask

  logic [15:0] z_v, clr_v, pe_v, err_v, e;

  initial begin
    z_v   = 16'h0000;
    clr_v = p4(1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pe_v  = p4(1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    err_v = p4(1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ksize=1 load, reload from RUN, then ERR entry/exit via bad ksize and mode changes.
    put(0,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, z_v);
    put(1,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, z_v);
    put(2,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, clr_v);
    put(3,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd0));
    put(4,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd1));
    put(5,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd2));
    put(6,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd3));
    put(7,  MOD_TYPE_A, 3'd1, 1'b1, 1'b1, pe_v);
    put(8,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, clr_v);
    put(9,  MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd0));
    put(10, MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd1));
    put(11, MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd2));
    put(12, MOD_TYPE_A, 3'd1, 1'b1, 1'b0, wr(5'd0, 2'd3));
    put(13, MOD_TYPE_A, 3'd1, 1'b1, 1'b0, pe_v);
    put(14, MOD_TYPE_B, 3'd0, 1'b1, 1'b0, pe_v);
    put(15, MOD_TYPE_B, 3'd0, 1'b1, 1'b0, z_v);
    put(16, MOD_TYPE_B, 3'd0, 1'b1, 1'b0, clr_v);
    put(17, MOD_TYPE_B, 3'd0, 1'b1, 1'b1, err_v);
    put(18, MOD_TYPE_B, 3'd0, 1'b1, 1'b0, err_v);
    put(19, 3'b000,     3'd6, 1'b1, 1'b0, err_v);
    put(20, 3'b011,     3'd6, 1'b1, 1'b0, z_v);
    put(21, 3'b011,     3'd6, 1'b1, 1'b0, z_v);
    put(22, MOD_TYPE_C, 3'd6, 1'b1, 1'b0, z_v);
    put(23, MOD_TYPE_C, 3'd6, 1'b1, 1'b0, z_v);
    put(24, MOD_TYPE_C, 3'd6, 1'b1, 1'b0, clr_v);
    put(25, MOD_TYPE_C, 3'd6, 1'b1, 1'b0, err_v);
    put(26, 3'b000,     3'd6, 1'b1, 1'b0, err_v);
    put(27, 3'b000,     3'd6, 1'b1, 1'b0, z_v);

    // Reset state, then idle with mode 0.
    rst = 1'b1; mode = 3'b000; ksize = 3'd0; reload = 1'b0; w_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_hold dut4", act4(), z_v);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #2;
      check($sformatf("idle dut1 c%0d", c), act1(), z_v);
      check($sformatf("idle dut4 c%0d", c), act4(), z_v);
      adv();
    end

    // Single channel, ksize=3, w_valid held high.
    do_reset();
    mode = MOD_TYPE_A; ksize = 3'd3; w_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #2;
      if (c < 2)       e = z_v;
      else if (c == 2) e = clr_v;
      else if (c < 12) e = wr(5'(c - 3), 2'd0);
      else             e = pe_v;
      check($sformatf("k3ch1 c%0d", c), act1(), e);
      adv();
    end

    // Four channels, ksize=2, w_valid alternating 1/0 from the first LOAD cycle.
    do_reset();
    mode = MOD_TYPE_A; ksize = 3'd2;
    for (int c = 0; c < 37; c++) begin
      w_valid = (c % 2) == 1;
      #2;
      if (c < 2)       e = z_v;
      else if (c == 2) e = clr_v;
      else if (c < 34) begin
        int k;
        k = (c - 3) / 2;
        if (((c - 3) % 2) == 0) e = wr(5'(k % 4), 2'(k / 4));
        else e = p4(1'b0, 5'((k + 1) % 4), 2'((k + 1) / 4), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end else         e = pe_v;
      check($sformatf("k2ch4 c%0d", c), act4(), e);
      adv();
    end

    // Mode change while loading at addr 4, then restart from addr 0 and async reset mid-load.
    do_reset();
    mode = MOD_TYPE_A; ksize = 3'd3; w_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #2;
      if (c < 2)       e = z_v;
      else if (c == 2) e = clr_v;
      else             e = wr(5'(c - 3), 2'd0);
      check($sformatf("abort c%0d", c), act4(), e);
      adv();
    end
    mode = MOD_TYPE_B;
    #2;
    check("abort chg_cycle", act4(), p4(1'b0, 5'd4, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    adv(); #2;
    check("abort idle", act4(), z_v);
    adv(); #2;
    check("abort clear", act4(), clr_v);
    adv(); #2;
    check("abort reload a0", act4(), wr(5'd0, 2'd0));
    adv(); #2;
    check("abort reload a1", act4(), wr(5'd1, 2'd0));
    adv(); #2;
    check("abort reload a2", act4(), wr(5'd2, 2'd0));
    #1;
    rst = 1'b1;
    #1;
    check("async_rst dut4", act4(), z_v);
    check("async_rst dut1", act1(), z_v);
    adv();
    rst = 1'b0;

    // Table: short loads, reload, non-one-hot mode, ERR on ksize 0 and 6.
    do_reset();
    for (int i = 0; i < 28; i++) begin
      mode    = tbl[i].mode;
      ksize   = tbl[i].ks;
      w_valid = tbl[i].wv;
      reload  = tbl[i].rl;
      #2;
      check($sformatf("tbl %0d", i), act4(), tbl[i].exp);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
